// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - Default memory address/data widths.
//   - Loader FSM state encoding (2'b11 is unused and recovers to LOAD).
package loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_WRITE = 2'b01,
    ST_RUN   = 2'b10
  } loader_state_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions the raw, bouncy, active-low write button.
//   CLOCK_50 : system clock
//   RESETn   : asynchronous active-low reset
//   key_n    : raw button level (active-low, asynchronous)
//   press    : registered one-cycle pulse on the debounced 1->0 transition
// The raw level goes through a 2-flop synchronizer. The stable level only
// follows the synchronized level after they have disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any agreement clears the counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESETn,
  input  logic key_n,
  output logic press
);

  // At least one counter bit so tiny debounce settings still elaborate.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Disagreement has lasted the full window: accept the new level.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Press is the accepted falling edge; release yields nothing.
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: operator front-end that owns the program memory write port
// while loading and gates the processor with cpu_run.
//   CLOCK_50, RESETn : clock, asynchronous active-low reset
//   KEY_n            : raw write button (active-low, bouncy)
//   SW_data          : byte to be written on a press
//   run_req          : level request to run the processor
//   mem_we/mem_addr/mem_wdata : memory write port (one-cycle strobe)
//   cpu_run          : processor enable
//   full             : every location has been written
//   count            : bytes written since reset
//   dbg_state        : current loader FSM state (debug visibility)
// Handshake: there is no back-pressure; a write is a single-cycle mem_we
// pulse with address and data held stable during that cycle, and the
// memory is assumed to accept it unconditionally.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              RESETn,
  input  logic              KEY_n,
  input  logic [DATA_W-1:0] SW_data,
  input  logic              run_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .CLOCK_50(CLOCK_50),
    .RESETn  (RESETn),
    .key_n   (KEY_n),
    .press   (press)
  );

  loader_state_e     state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              run_q;
  logic              full_q;
  logic [ADDR_W:0]   count_q;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_LOAD;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      full_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      // The strobe is only ever raised for the single WRITE cycle.
      mem_we_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          // A press beats run_req; presses once full are dropped.
          if (press && !full_q) begin
            wdata_q  <= SW_data;
            mem_we_q <= 1'b1;
            state_q  <= ST_WRITE;
          end else if (run_req) begin
            run_q   <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_WRITE: begin
          count_q <= count_q + CNT_ONE;
          // The last location pins the address and marks the memory full.
          if (addr_q == ADDR_MAX) begin
            full_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
          state_q <= ST_LOAD;
        end
        ST_RUN: begin
          // Presses are ignored here; address/count persist so loads append.
          if (!run_req) begin
            run_q   <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        default: begin
          run_q   <= 1'b0;
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = run_q;
  assign full      = full_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed + randomized bench for prog_loader with a short
// debounce window. Expected writes come from a simple model: the n-th
// accepted byte lands at location n, nothing is accepted while running or
// once all locations are used.
module tb_prog_loader;

  localparam int D     = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  // Clock / reset / DUT
  logic          CLOCK_50 = 1'b0;
  logic          RESETn;
  logic          KEY_n;
  logic [DW-1:0] SW_data;
  logic          run_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_run;
  logic          full;
  logic [AW:0]   count;
  logic [1:0]    dbg_state;

  always #5 CLOCK_50 = ~CLOCK_50;

  prog_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESETn   (RESETn),
    .KEY_n    (KEY_n),
    .SW_data  (SW_data),
    .run_req  (run_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_run  (cpu_run),
    .full     (full),
    .count    (count),
    .dbg_state(dbg_state)
  );

  // Scoreboard state
  int checks      = 0;
  int errors      = 0;
  int writes_seen = 0;
  int model_count = 0;
  bit model_run   = 1'b0;
  logic [AW+DW-1:0] exp_q[$];
  logic prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic void model_accept(input logic [DW-1:0] d);
    if (!model_run && model_count < DEPTH) begin
      exp_q.push_back({AW'(model_count), d});
      model_count++;
    end
  endfunction

  // One press/release with optional short leading glitch.
  task automatic press(input logic [DW-1:0] d, input int low_cyc, input bit glitch);
    SW_data = d;
    if (glitch) begin
      KEY_n = 1'b0;
      ticks($urandom_range(1, D - 1));
      KEY_n = 1'b1;
      ticks(1);
    end
    model_accept(d);
    KEY_n = 1'b0;
    ticks(low_cyc);
    KEY_n = 1'b1;
    ticks(D + 5);
    chk("write_drained", exp_q.size(), 0);
  endtask

  // Write monitor, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (RESETn === 1'b1 && mem_we === 1'b1) begin
      logic [AW+DW-1:0] e;
      writes_seen++;
      chk("we_single_cycle", prev_we, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[AW+DW-1:DW]);
        chk("wr_data", mem_wdata, e[DW-1:0]);
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lat;
    int ws;
    bit seen;
    logic [DW-1:0] d;

    KEY_n   = 1'b1;
    run_req = 1'b0;
    SW_data = '0;
    RESETn  = 1'b0;
    ticks(3);

    // Reset values
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_state", dbg_state, 0);
    RESETn = 1'b1;
    ticks(2);

    // Three clean entries
    press(8'h12, 6, 1'b0);
    press(8'h34, 6, 1'b0);
    press(8'h56, 6, 1'b0);
    chk("three_count", count, 3);
    chk("three_addr", mem_addr, 3);

    // Bounce rejection: low 3, high 2, low 3
    ws = writes_seen;
    SW_data = 8'hEE;
    KEY_n = 1'b0; ticks(3);
    KEY_n = 1'b1; ticks(2);
    KEY_n = 1'b0; ticks(3);
    KEY_n = 1'b1; ticks(D + 5);
    chk("bounce_no_write", writes_seen - ws, 0);
    chk("bounce_count", count, 3);

    // Minimum 5-cycle press; latency from first low sample to mem_we
    d = DW'($urandom);
    SW_data = d;
    model_accept(d);
    KEY_n = 1'b0;
    lat = -1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!seen && mem_we === 1'b1) begin
        seen = 1'b1;
        lat = k - 1;  // tick 1 lands just after the first low sample
      end
      if (k == 5) KEY_n = 1'b1;
    end
    chk("press_latency", lat, 2 + D + 1);
    chk("latency_drained", exp_q.size(), 0);

    // Run and append
    run_req = 1'b1;
    model_run = 1'b1;
    tick();
    chk("run_cpu_run", cpu_run, 1);
    chk("run_state", dbg_state, 2);
    press(DW'($urandom), 6, 1'b0);
    chk("run_still_running", cpu_run, 1);
    chk("run_count_held", count, model_count);
    run_req = 1'b0;
    model_run = 1'b0;
    tick();
    chk("run_exit_cpu_run", cpu_run, 0);
    press(DW'($urandom), 6, 1'b0);
    chk("append_count", count, model_count);

    // Press event and run_req in the same cycle: write first, run after
    d = DW'($urandom);
    SW_data = d;
    model_accept(d);
    KEY_n = 1'b0;
    ticks(2 + D + 1);
    run_req = 1'b1;
    tick();
    chk("same_we", mem_we, 1);
    chk("same_run_0", cpu_run, 0);
    tick();
    chk("same_we_off", mem_we, 0);
    chk("same_run_1", cpu_run, 0);
    tick();
    chk("same_run_2", cpu_run, 1);
    KEY_n = 1'b1;
    ticks(D + 5);
    run_req = 1'b0;
    tick();
    chk("same_run_exit", cpu_run, 0);
    chk("same_drained", exp_q.size(), 0);

    // Random presses with random hold times and glitches
    repeat (20) press(DW'($urandom), $urandom_range(5, 10), 1'($urandom_range(0, 1)));
    chk("rand_count", count, model_count);

    // Fill remaining locations
    while (model_count < DEPTH) press(DW'($urandom), 5, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, DEPTH);
    chk("fill_addr", mem_addr, DEPTH - 1);

    // Press once full is discarded
    ws = writes_seen;
    press(DW'($urandom), 6, 1'b1);
    chk("overfill_no_write", writes_seen - ws, 0);
    chk("overfill_count", count, DEPTH);

    // Reset during WRITE aborts it
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    model_count = 0;
    tick();
    SW_data = DW'($urandom);
    KEY_n = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mem_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_write_reached", seen, 1);
    ws = writes_seen;
    RESETn = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_count", count, 0);
    chk("abort_cpu_run", cpu_run, 0);
    chk("abort_full", full, 0);
    KEY_n = 1'b1;
    ticks(3);
    RESETn = 1'b1;
    ticks(D + 6);
    chk("abort_no_more_writes", writes_seen - ws, 0);
    chk("abort_count_after", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Front-end loader that sits directly upstream of the processor's 256×8 program/data memory write port. It lets the operator enter program bytes from the board switches one at a time with a push button, holding the processor stalled while loading. On request, it releases the processor to run. It owns the memory write port while in load mode and drives a run-enable that gates the processor FSM.

## Interface

Reset is asynchronous, active-low. There is one clock, CLOCK_50.

**Parameters**
- ADDR_W, default 8: memory address width. Memory depth is 2^ADDR_W.
- DATA_W, default 8: memory word width.
- DEBOUNCE_CYCLES, default 500000: cycles the synchronized button level must be stable before it is accepted. The default is 10 ms at 50 MHz.

**Ports**
- CLOCK_50, in, 1: system clock.
- RESETn, in, 1: asynchronous active-low reset.
- KEY_n, in, 1: raw write button, active-low, asynchronous and bouncy.
- SW_data, in, DATA_W: byte to write.
- run_req, in, 1: level request to run the processor.
- mem_we, out, 1: memory write strobe, one cycle wide.
- mem_addr, out, ADDR_W: write address.
- mem_wdata, out, DATA_W: write data.
- cpu_run, out, 1: high enables the processor FSM/PC.
- full, out, 1: all 2^ADDR_W locations have been written.
- count, out, ADDR_W+1: number of bytes written since reset.

## Operation

**Button conditioning**
- KEY_n passes through a 2-flop synchronizer.
- The debouncer updates its stable level only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any match resets the stability counter to 0.
- A press event is a one-cycle pulse on the stable level's 1→0 transition. Release produces no event.

**State machine**
- **LOAD** (reset state)
  - If a press event occurs and full=0, capture SW_data into mem_wdata and go to WRITE.
  - Otherwise, if run_req=1, go to RUN.
  - A press event takes priority over run_req in the same cycle.
- **WRITE**
  - mem_we=1 for exactly this cycle; mem_addr and mem_wdata are stable.
  - Next state is LOAD. On exit, count is incremented.
  - On exit, mem_addr is incremented unless it equals 2^ADDR_W−1. In that case mem_addr holds and full is set.
- **RUN**
  - cpu_run=1 and mem_we=0.
  - Press events are discarded, not queued.
  - If run_req=0, go to LOAD with mem_addr, count and full preserved, so new bytes append.
- In LOAD with full=1, press events are discarded.

**Reset values:** mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, full=0, count=0, state=LOAD. The synchronizer flops and the stable level reset to 1 (released), and the stability counter resets to 0.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Press latency: KEY_n is first sampled low at edge t and held low. The stable level falls at edge t+2+DEBOUNCE_CYCLES. mem_we is high during the cycle following edge t+3+DEBOUNCE_CYCLES.
- Minimum spacing between two writes is 2×DEBOUNCE_CYCLES plus the synchronizer delay, because a release must also be debounced.
- cpu_run rises on the first edge after run_req=1 is sampled in LOAD. It falls on the first edge after run_req=0 is sampled in RUN.
- An asynchronous reset assertion forces all outputs to their reset values immediately, including mid-WRITE; that write is aborted. Deassertion is synchronized externally.

## Structure

**Shared package loader_pkg**
- State encoding: LOAD=2'b00, WRITE=2'b01, RUN=2'b10. 2'b11 is illegal and recovers to LOAD.
- ADDR_W and DATA_W defaults.

**Sub-module key_debounce**
- Contains the synchronizer, stability counter ($clog2(DEBOUNCE_CYCLES+1) bits) and falling-edge pulse.
- Ports: CLOCK_50, RESETn, key_n, press.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4.

- **Three entries:** SW_data=0x12, 0x34, 0x56, each with a clean press/release. Expect writes of 0x12@0x00, 0x34@0x01, 0x56@0x02, with count=3 and mem_addr=0x03.
- **Bounce rejection:** toggle KEY_n low for 3 cycles, then high 2, then low 3. Expect no mem_we. A subsequent 5-cycle low produces exactly one write, with mem_we appearing exactly 7 edges after the first low sample.
- **Fill:** perform 256 presses. The last write is @0xFF, after which full=1, count=256 and mem_addr=0xFF. A 257th press produces no mem_we.
- **Run and append:** after 2 writes, set run_req=1; expect cpu_run=1 the next cycle. A press while in RUN produces no mem_we. Set run_req=0; the next press writes @0x02.
- **Same-cycle press and run_req:** assert run_req on the press-event cycle. Expect WRITE to occur first, then RUN two cycles later.
- **Reset mid-write:** assert RESETn=0 during WRITE. Expect mem_we=0, mem_addr=0, count=0 and cpu_run=0 immediately, with no further writes.
